// File: rtl/result_uart_tx_if.sv
// Signal bundle between the solver result and the UART result reporter.
// The solver drives Done/Error/Answer; the reporter drives Tx/Busy/Sent.
interface result_uart_tx_if #(
    parameter int unsigned ANSWER_WIDTH = 64
);
    logic                    Done;
    logic                    Error;
    logic [ANSWER_WIDTH-1:0] Answer;
    logic                    Tx;
    logic                    Busy;
    logic                    Sent;

    modport master (output Done, Error, Answer, input Tx, Busy, Sent);
    modport slave  (input Done, Error, Answer, output Tx, Busy, Sent);
endinterface

// File: rtl/result_uart_tx.sv
// Captures the solver result once per reset, converts it to decimal ASCII
// and sends it as one CR/LF-terminated line over an 8N1 UART.
module result_uart_tx #(
    parameter int unsigned CLK_FREQ_HZ  = 125000000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned ANSWER_WIDTH = 64,
    parameter int unsigned MAX_DIGITS   = 20
) (
    input logic             Clk,
    input logic             Rst_n,
    result_uart_tx_if.slave bus
);
    localparam int unsigned CLKS_PER_BIT = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned SW = $clog2(ANSWER_WIDTH + 1);
    localparam int unsigned IW = $clog2(MAX_DIGITS + 3);
    localparam int unsigned BW = 4 * MAX_DIGITS;

    typedef enum logic [1:0] {StIdle, StConvert, StSend, StFinished} state_e;

    state_e                  state_q, state_d;
    logic [ANSWER_WIDTH-1:0] bin_q, bin_d;
    logic [BW-1:0]           bcd_q, bcd_d, bcd_shift;
    logic                    err_q, err_d;
    logic [SW-1:0]           shift_cnt_q, shift_cnt_d;
    logic [CW-1:0]           baud_cnt_q, baud_cnt_d;
    logic [3:0]              bit_idx_q, bit_idx_d;
    logic [IW-1:0]           byte_idx_q, byte_idx_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic                    sent_q, sent_d;

    logic [3:0]    nib;
    logic          carry;
    logic [IW-1:0] ndig, nib_idx, last_idx;
    logic [3:0]    digit;
    logic [7:0]    cur_byte;

    // One double-dabble step: add-3 on nibbles >= 5, then shift in the next binary bit.
    always_comb begin
        bcd_shift = '0;
        nib       = '0;
        carry     = bin_q[ANSWER_WIDTH-1];
        for (int i = 0; i < MAX_DIGITS; i++) begin
            nib = bcd_q[4*i +: 4];
            if (nib >= 4'd5) nib = nib + 4'd3;
            bcd_shift[4*i +: 4] = {nib[2:0], carry};
            carry = nib[3];
        end
    end

    // Byte currently on the wire: significant digits, then CR, then LF.
    always_comb begin
        ndig = IW'(1);
        for (int i = 1; i < MAX_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) ndig = IW'(i + 1);
        end
        nib_idx = ndig - IW'(1) - byte_idx_q;
        digit   = 4'd0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (nib_idx == IW'(i)) digit = bcd_q[4*i +: 4];
        end
        last_idx = err_q ? IW'(4) : ndig + IW'(1);
        cur_byte = 8'h0A;
        if (err_q) begin
            case (byte_idx_q)
                IW'(0):  cur_byte = 8'h45;
                IW'(1):  cur_byte = 8'h52;
                IW'(2):  cur_byte = 8'h52;
                IW'(3):  cur_byte = 8'h0D;
                default: cur_byte = 8'h0A;
            endcase
        end else if (byte_idx_q < ndig) begin
            cur_byte = {4'h3, digit};
        end else if (byte_idx_q == ndig) begin
            cur_byte = 8'h0D;
        end
    end

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        err_d       = err_q;
        shift_cnt_d = shift_cnt_q;
        baud_cnt_d  = baud_cnt_q;
        bit_idx_d   = bit_idx_q;
        byte_idx_d  = byte_idx_q;
        tx_d        = tx_q;
        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (bus.Done || bus.Error) begin
                    bin_d       = bus.Answer;
                    err_d       = bus.Error;
                    bcd_d       = '0;
                    shift_cnt_d = '0;
                    if (bus.Error) begin
                        state_d    = StSend;
                        tx_d       = 1'b0;
                        baud_cnt_d = '0;
                        bit_idx_d  = '0;
                        byte_idx_d = '0;
                    end else begin
                        state_d = StConvert;
                    end
                end
            end
            StConvert: begin
                bcd_d       = bcd_shift;
                bin_d       = bin_q << 1;
                shift_cnt_d = shift_cnt_q + 1'b1;
                if (shift_cnt_q == SW'(ANSWER_WIDTH - 1)) begin
                    state_d    = StSend;
                    tx_d       = 1'b0;
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    byte_idx_d = '0;
                end
            end
            StSend: begin
                baud_cnt_d = baud_cnt_q + 1'b1;
                if (baud_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == 4'd9) begin
                        if (byte_idx_q == last_idx) begin
                            state_d = StFinished;
                            tx_d    = 1'b1;
                        end else begin
                            byte_idx_d = byte_idx_q + 1'b1;
                            bit_idx_d  = '0;
                            tx_d       = 1'b0;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        tx_d      = (bit_idx_q == 4'd8) ? 1'b1 : cur_byte[bit_idx_q[2:0]];
                    end
                end
            end
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d == StConvert) || (state_d == StSend);
        sent_d = (state_d == StFinished);
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q     <= StIdle;
            bin_q       <= '0;
            bcd_q       <= '0;
            err_q       <= 1'b0;
            shift_cnt_q <= '0;
            baud_cnt_q  <= '0;
            bit_idx_q   <= '0;
            byte_idx_q  <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            sent_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            err_q       <= err_d;
            shift_cnt_q <= shift_cnt_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_idx_q   <= bit_idx_d;
            byte_idx_q  <= byte_idx_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            sent_q      <= sent_d;
        end
    end

    assign bus.Tx   = tx_q;
    assign bus.Busy = busy_q;
    assign bus.Sent = sent_q;
endmodule
